uartms_reg_master: RTL and testbench

UARTMS_REG_MASTER -- requirements
Module: uartms_reg_master

---
 rtl/uartms_pkg.sv | 41 ++++
 rtl/uartms_bus_cyc.sv | 62 ++++++
 rtl/uartms_reg_master.sv | 143 ++++++++++++++
 tb/tb_uartms_reg_master.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uartms_pkg.sv
// Shared UART register-map constants and bus request helpers.
package uartms_pkg;

  // UART core register addresses.
  localparam logic [3:0] ADDR_CTRL    = 4'h0;
  localparam logic [3:0] ADDR_INTR    = 4'h1;
  localparam logic [3:0] ADDR_BAUD_LO = 4'h2;
  localparam logic [3:0] ADDR_BAUD_HI = 4'h3;
  localparam logic [3:0] ADDR_STAT    = 4'h4;
  localparam logic [3:0] ADDR_TXD     = 4'h5;
  localparam logic [3:0] ADDR_RXD     = 4'h6;

  // Status register bit positions.
  localparam int STAT_TX_FULL  = 0;
  localparam int STAT_RX_EMPTY = 1;

  // One register-bus request as presented to the bus-cycle engine.
  typedef struct packed {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wdata;
  } bus_req_t;

  function automatic bus_req_t wr_req(input logic [3:0] addr, input logic [7:0] data);
    bus_req_t r;
    r.wr    = 1'b1;
    r.addr  = addr;
    r.wdata = data;
    return r;
  endfunction

  // Reads drive zero on the write-data lines.
  function automatic bus_req_t rd_req(input logic [3:0] addr);
    bus_req_t r;
    r.wr    = 1'b0;
    r.addr  = addr;
    r.wdata = 8'h00;
    return r;
  endfunction

endpackage

// File: rtl/uartms_bus_cyc.sv
// Single register-bus cycle engine: launches one access, holds it until
// acknowledged, or abandons it after ACK_TMO cycles without an ack.
module uartms_bus_cyc #(
  parameter int ACK_TMO = 15
) (
  input  logic       mclk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       wr,
  input  logic [3:0] addr,
  input  logic [7:0] wdata,
  output logic       done,
  output logic       tmo,
  output logic [7:0] rdata,
  output logic       reg_cs,
  output logic       reg_wr,
  output logic       reg_be,
  output logic [3:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  input  logic       reg_ack
);

  // Counter value in the last cycle reg_cs may stay high without an ack.
  localparam logic [3:0] TMO_LAST = 4'(ACK_TMO - 1);

  logic [3:0] tmo_cnt_reg;

  // done/tmo are valid in the cycle the engine finishes; rdata is only
  // meaningful alongside done, and the consumer captures it at that edge.
  assign done  = reg_cs && reg_ack;
  assign tmo   = reg_cs && !reg_ack && (tmo_cnt_reg == TMO_LAST);
  assign rdata = reg_rdata;

  // Launch on start while idle; hold the request until ack or timeout.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      reg_cs      <= 1'b0;
      reg_wr      <= 1'b0;
      reg_be      <= 1'b0;
      reg_addr    <= 4'h0;
      reg_wdata   <= 8'h00;
      tmo_cnt_reg <= 4'd0;
    end else if (reg_cs) begin
      if (done || tmo) begin
        reg_cs <= 1'b0;
        reg_wr <= 1'b0;
        reg_be <= 1'b0;
      end else begin
        tmo_cnt_reg <= tmo_cnt_reg + 4'd1;
      end
    end else if (start) begin
      reg_cs      <= 1'b1;
      reg_be      <= 1'b1;
      reg_wr      <= wr;
      reg_addr    <= addr;
      reg_wdata   <= wdata;
      tmo_cnt_reg <= 4'd0;
    end
  end

endmodule

// File: rtl/uartms_reg_master.sv
// Register-bus master for a UART core: programs control/baud on request,
// then polls status and moves bytes between the UART FIFOs and the
// tx/rx streaming handshakes.
module uartms_reg_master
  import uartms_pkg::*;
#(
  parameter logic [7:0]  CTRL_INIT = 8'h83,
  parameter logic [11:0] BAUD_INIT = 12'd0,
  parameter int          ACK_TMO   = 15
) (
  input  logic       mclk,
  input  logic       reset_n,
  input  logic       init_req,
  output logic       init_done,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       bus_err,
  output logic       reg_cs,
  output logic       reg_wr,
  output logic       reg_be,
  output logic [3:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  input  logic       reg_ack
);

  typedef enum logic [2:0] {
    IDLE, INIT_CTRL, INIT_BLO, INIT_BHI, POLL, RX_RD, TX_WR
  } state_t;

  state_t     state_reg;
  logic       pending_reg;
  bus_req_t   req;
  logic       in_init;
  logic       cyc_start;
  logic       cyc_done;
  logic       cyc_tmo;
  logic [7:0] cyc_rdata;

  // Request presented to the engine for the access owned by each state.
  always_comb begin
    req = rd_req(ADDR_STAT);
    case (state_reg)
      INIT_CTRL: req = wr_req(ADDR_CTRL, CTRL_INIT);
      INIT_BLO:  req = wr_req(ADDR_BAUD_LO, BAUD_INIT[7:0]);
      INIT_BHI:  req = wr_req(ADDR_BAUD_HI, {4'h0, BAUD_INIT[11:8]});
      RX_RD:     req = rd_req(ADDR_RXD);
      TX_WR:     req = wr_req(ADDR_TXD, tx_data);
      default:   req = rd_req(ADDR_STAT);
    endcase
  end

  assign in_init = state_reg inside {INIT_CTRL, INIT_BLO, INIT_BHI};

  // A new access starts in every cycle reg_cs is low outside IDLE, which
  // gives exactly one idle cycle after each access. An init_req arriving in
  // that idle cycle suppresses the launch so the restart begins cleanly.
  assign cyc_start = (state_reg != IDLE) && !reg_cs && !init_req;

  // The byte is taken in the very cycle the UART acks the TXD write, so
  // tx_ready is decoded from the ack rather than registered.
  assign tx_ready = (state_reg == TX_WR) && cyc_done;

  uartms_bus_cyc #(.ACK_TMO(ACK_TMO)) u_bus_cyc (
    .mclk      (mclk),
    .reset_n   (reset_n),
    .start     (cyc_start),
    .wr        (req.wr),
    .addr      (req.addr),
    .wdata     (req.wdata),
    .done      (cyc_done),
    .tmo       (cyc_tmo),
    .rdata     (cyc_rdata),
    .reg_cs    (reg_cs),
    .reg_wr    (reg_wr),
    .reg_be    (reg_be),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .reg_ack   (reg_ack)
  );

  // Sequencer: init writes, status polling, rx/tx transfers and restarts.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      pending_reg <= 1'b0;
      init_done   <= 1'b0;
      bus_err     <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= 8'h00;
    end else begin
      if (init_req) begin
        bus_err   <= 1'b0;
        init_done <= 1'b0;
      end
      if (cyc_tmo) bus_err <= 1'b1;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (state_reg == IDLE) begin
        if (init_req) state_reg <= INIT_CTRL;
      end else if (cyc_done || cyc_tmo) begin
        pending_reg <= 1'b0;
        if (cyc_done && state_reg == RX_RD) begin
          rx_data  <= cyc_rdata;
          rx_valid <= 1'b1;
        end
        if (init_req || pending_reg) begin
          state_reg <= INIT_CTRL;
        end else if (cyc_tmo) begin
          state_reg <= in_init ? INIT_CTRL : POLL;
        end else begin
          case (state_reg)
            INIT_CTRL: state_reg <= INIT_BLO;
            INIT_BLO:  state_reg <= INIT_BHI;
            INIT_BHI: begin
              init_done <= 1'b1;
              state_reg <= POLL;
            end
            POLL: begin
              if (!cyc_rdata[STAT_RX_EMPTY] && !rx_valid)
                state_reg <= RX_RD;
              else if (tx_valid && !cyc_rdata[STAT_TX_FULL])
                state_reg <= TX_WR;
              else
                state_reg <= POLL;
            end
            default: state_reg <= POLL;
          endcase
        end
      end else if (init_req) begin
        // Let an in-flight access finish; restart straight away otherwise.
        if (reg_cs) pending_reg <= 1'b1;
        else        state_reg   <= INIT_CTRL;
      end
    end
  end

endmodule

// File: tb/tb_uartms_reg_master.sv
// Directed bench for uartms_reg_master with a register-bus responder model
// and a scoreboard of expected non-status bus accesses and rx bytes.
module tb_uartms_reg_master;
  import uartms_pkg::*;

  logic       mclk = 1'b0;
  logic       reset_n = 1'b0;
  logic       init_req = 1'b0;
  logic       init_done;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready = 1'b0;
  logic       bus_err;
  logic       reg_cs, reg_wr, reg_be;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata = 8'h00;
  logic       reg_ack = 1'b0;

  always #5 mclk = ~mclk;

  uartms_reg_master #(.CTRL_INIT(8'h83), .BAUD_INIT(12'h145), .ACK_TMO(15)) dut (
    .mclk(mclk), .reset_n(reset_n), .init_req(init_req), .init_done(init_done),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .bus_err(bus_err),
    .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_be(reg_be), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ack(reg_ack)
  );

  typedef struct {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wdata;
  } txn_t;

  txn_t       exp_q[$];
  logic [7:0] rx_exp_q[$];
  logic [7:0] rx_byte_q[$];
  int  checks = 0;
  int  errors = 0;
  int  tx_pulses = 0;
  int  tx_target = 0;
  int  poll_cnt = 0;
  int  poll_mark = 0;
  int  cs_age = 0;
  int  tmo_len = 0;
  bit  ack_en = 1'b1;
  bit  tx_full = 1'b1;
  bit  acked = 1'b0;
  bit  after_ack = 1'b0;
  txn_t       mon_e;
  logic [7:0] rx_e;

  function automatic txn_t mk(input logic wr, input logic [3:0] addr, input logic [7:0] d);
    txn_t t;
    t.wr = wr; t.addr = addr; t.wdata = d;
    return t;
  endfunction

  // Responder (acks in the second cs cycle) followed by the output monitor.
  always @(negedge mclk) begin
    if (reg_cs) begin
      cs_age++;
      if (ack_en && cs_age >= 2) begin
        reg_ack = 1'b1;
        acked   = 1'b1;
        if (reg_addr == ADDR_STAT)
          reg_rdata = {6'b0, (rx_byte_q.size() == 0), tx_full};
        else if (reg_addr == ADDR_RXD && !reg_wr)
          reg_rdata = (rx_byte_q.size() != 0) ? rx_byte_q.pop_front() : 8'hEE;
        else
          reg_rdata = 8'h00;
      end else begin
        reg_ack = 1'b0;
      end
    end else begin
      if (cs_age != 0 && !acked) tmo_len = cs_age;
      cs_age  = 0;
      acked   = 1'b0;
      reg_ack = 1'b0;
    end
    #1;
    if (reg_cs && reg_ack) begin
      checks++;
      assert (tx_ready === (reg_wr && reg_addr == ADDR_TXD)) else begin
        errors++;
        $error("FAIL tx_ready_in_ack: observed %b expected %b (addr %0h)", tx_ready,
               (reg_wr && reg_addr == ADDR_TXD), reg_addr);
      end
      if (tx_ready) tx_pulses++;
      if (reg_addr == ADDR_STAT && !reg_wr) begin
        poll_cnt++;
      end else begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_txn: observed wr=%b addr=%0h data=%0h expected none",
                 reg_wr, reg_addr, reg_wdata);
        end
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          checks++;
          assert (reg_wr === mon_e.wr && reg_addr === mon_e.addr &&
                  (!mon_e.wr || reg_wdata === mon_e.wdata)) else begin
            errors++;
            $error("FAIL bus_txn: observed wr=%b addr=%0h data=%0h expected wr=%b addr=%0h data=%0h",
                   reg_wr, reg_addr, reg_wdata, mon_e.wr, mon_e.addr, mon_e.wdata);
          end
        end
      end
      if (reg_wr && reg_addr == ADDR_BAUD_HI) begin
        checks++;
        assert (init_done === 1'b0) else begin
          errors++;
          $error("FAIL init_done_before_ack: observed %b expected 0", init_done);
        end
      end
      after_ack = 1'b1;
    end else begin
      if (after_ack) begin
        checks++;
        assert (reg_cs === 1'b0) else begin
          errors++;
          $error("FAIL idle_after_ack: observed reg_cs %b expected 0", reg_cs);
        end
      end
      after_ack = 1'b0;
      checks++;
      assert (tx_ready === 1'b0) else begin
        errors++;
        $error("FAIL tx_ready_stray: observed %b expected 0", tx_ready);
      end
    end
    if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
      rx_e = (rx_exp_q.size() != 0) ? rx_exp_q.pop_front() : 8'hxx;
      checks++;
      assert (rx_data === rx_e) else begin
        errors++;
        $error("FAIL rx_byte: observed %0h expected %0h", rx_data, rx_e);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic bit cond(input int which);
    case (which)
      0:       return init_done === 1'b1;
      1:       return tx_pulses == tx_target;
      2:       return rx_exp_q.size() == 0;
      3:       return bus_err === 1'b1;
      4:       return poll_cnt > poll_mark;
      5:       return reg_cs === 1'b1 && reg_wr === 1'b1 && reg_addr == ADDR_TXD && reg_ack === 1'b0;
      6:       return reg_cs === 1'b1 && reg_ack === 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  // Bounded wait; an expired bound is a failed comparison.
  task automatic wait_for(input int which, input int limit, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (cond(which)) begin
        ok = 1'b1;
        break;
      end
      @(negedge mclk);
      #2;
    end
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL %s: observed timeout after %0d cycles expected event", tag, limit);
    end
  endtask

  task automatic pulse_init();
    @(negedge mclk);
    #2 init_req = 1'b1;
    @(negedge mclk);
    init_req = 1'b0;
  endtask

  task automatic push_init();
    exp_q.push_back(mk(1'b1, ADDR_CTRL, 8'h83));
    exp_q.push_back(mk(1'b1, ADDR_BAUD_LO, 8'h45));
    exp_q.push_back(mk(1'b1, ADDR_BAUD_HI, 8'h01));
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge mclk);
    #2;
    chk("reset_bus", {reg_cs, reg_wr, reg_be, reg_addr, reg_wdata}, 32'h0);
    chk("reset_flags", {init_done, rx_valid, tx_ready, bus_err}, 32'h0);
    chk("reset_rx_data", rx_data, 32'h0);
    @(negedge mclk);
    reset_n = 1'b1;
    repeat (4) @(negedge mclk);
    #2 chk("idle_no_cycle", reg_cs, 32'h0);

    // Init sequence: 0:83, 2:45, 3:01
    push_init();
    pulse_init();
    wait_for(0, 60, "init_done");
    chk("init_all_writes", exp_q.size(), 32'h0);

    // One rx byte, tx full
    @(negedge mclk);
    rx_ready = 1'b1;
    exp_q.push_back(mk(1'b0, ADDR_RXD, 8'h00));
    rx_exp_q.push_back(8'hA5);
    rx_byte_q.push_back(8'hA5);
    wait_for(2, 60, "rx_a5");
    repeat (2) @(negedge mclk);
    #2 chk("rx_valid_one_cycle", rx_valid, 32'h0);
    chk("rx_read_done", exp_q.size(), 32'h0);

    // One tx byte, tx not full
    tx_full  = 1'b0;
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    exp_q.push_back(mk(1'b1, ADDR_TXD, 8'h3C));
    tx_target = 1;
    wait_for(1, 60, "tx_3c");
    tx_valid = 1'b0;
    @(negedge mclk);
    #2 chk("cs_low_after_tx", reg_cs, 32'h0);
    repeat (20) @(negedge mclk);
    #2 chk("single_tx", tx_pulses, 32'd1);

    // Backpressure: second byte must wait for rx_ready
    @(negedge mclk);
    rx_ready = 1'b0;
    exp_q.push_back(mk(1'b0, ADDR_RXD, 8'h00));
    rx_exp_q.push_back(8'h11);
    rx_exp_q.push_back(8'h22);
    rx_byte_q.push_back(8'h11);
    rx_byte_q.push_back(8'h22);
    repeat (40) @(negedge mclk);
    #2;
    chk("rx_held_valid", rx_valid, 32'h1);
    chk("rx_held_data", rx_data, 32'h11);
    chk("rx_second_pending", rx_byte_q.size(), 32'd1);
    exp_q.push_back(mk(1'b0, ADDR_RXD, 8'h00));
    @(negedge mclk);
    rx_ready = 1'b1;
    wait_for(2, 80, "rx_drain");
    chk("rx_reads_done", exp_q.size(), 32'h0);

    // Responder silent: timeout after 15 cycles of reg_cs
    @(negedge mclk);
    #2 ack_en = 1'b0;
    wait_for(3, 60, "bus_err_set");
    chk("tmo_cs_cycles", tmo_len, 32'd15);
    chk("cs_dropped_on_tmo", reg_cs, 32'h0);
    ack_en = 1'b1;
    poll_mark = poll_cnt;
    wait_for(4, 60, "poll_resume");
    chk("bus_err_sticky", bus_err, 32'h1);
    push_init();
    pulse_init();
    #2;
    chk("bus_err_cleared", bus_err, 32'h0);
    chk("init_done_cleared", init_done, 32'h0);
    wait_for(0, 80, "reinit_done");
    chk("reinit_writes", exp_q.size(), 32'h0);

    // init_req during the TXD write
    tx_data = 8'h5A;
    exp_q.push_back(mk(1'b1, ADDR_TXD, 8'h5A));
    push_init();
    tx_valid = 1'b1;
    tx_target = 2;
    wait_for(5, 60, "tx_cycle_start");
    init_req = 1'b1;
    @(negedge mclk);
    init_req = 1'b0;
    wait_for(1, 20, "tx_5a");
    tx_valid = 1'b0;
    chk("init_done_low_mid", init_done, 32'h0);
    wait_for(0, 80, "restart_done");
    chk("restart_writes", exp_q.size(), 32'h0);

    // Reset in the middle of an access drops reg_cs at once
    wait_for(6, 30, "cs_for_reset");
    reset_n = 1'b0;
    #1;
    chk("reset_mid_cs", reg_cs, 32'h0);
    chk("reset_mid_flags", {init_done, rx_valid, tx_ready}, 32'h0);
    repeat (2) @(negedge mclk);
    #2;
    chk("total_tx", tx_pulses, 32'd2);
    chk("rx_all_seen", rx_exp_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
